// File: rtl/sd_sector_scheduler.sv
// sd_sector_scheduler: decides when a full sector is waiting in the write FIFO,
// launches one SD sector write, tracks the sector address (wrapping between
// START_SECTOR and END_SECTOR) and counts completed sectors.
// Optional feature macro: SD_SCHED_TIMEOUT_EN adds a per-sector busy watchdog
// that parks the FSM in S_ERR with a sticky err_timeout flag.
//
// Handshake with the SD write controller: wr_en is a one-cycle start pulse
// issued from S_REQ with wr_addr already stable; the controller acknowledges
// by raising wr_busy (a level already high counts as the acknowledge) and
// signals completion by dropping wr_busy. wr_addr does not change until the
// FSM leaves S_NEXT.
module sd_sector_scheduler #(
    parameter logic [11:0] DATA_NUM     = 12'd256,
    parameter logic [31:0] START_SECTOR = 32'd1000,
    parameter logic [31:0] END_SECTOR   = 32'd1999,
    parameter logic [23:0] TIMEOUT_MAX  = 24'd5_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic        log_en,
    input  logic [11:0] fifo_data_num,
    input  logic        wr_busy,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] sector_cnt,
    output logic        wrap_pulse,
    output logic        sched_busy,
    output logic        err_timeout,
    output logic [2:0]  state_dbg_o
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_REQ  = 3'd2,
        S_ACK  = 3'd3,
        S_BUSY = 3'd4,
        S_NEXT = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] sector_cnt_q, sector_cnt_d;
    logic        wrap_q, wrap_d;
    logic        timeout_hit;

`ifdef SD_SCHED_TIMEOUT_EN
    logic [23:0] wdog_q, wdog_d;
    logic        err_q, err_d;

    // Watchdog: cleared while requesting (i.e. on entry to S_ACK), counts in S_ACK/S_BUSY
    always_comb begin
        wdog_d      = wdog_q;
        err_d       = err_q;
        timeout_hit = 1'b0;
        if (state_q == S_REQ) begin
            wdog_d = '0;
        end else if (state_q == S_ACK || state_q == S_BUSY) begin
            wdog_d = wdog_q + 24'd1;
            if (wdog_d == TIMEOUT_MAX) begin
                timeout_hit = 1'b1;
                err_d       = 1'b1;
            end
        end
    end

    // Watchdog and sticky error registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    logic unused_timeout_max;
    assign unused_timeout_max = ^TIMEOUT_MAX;
    assign timeout_hit        = 1'b0;
    assign err_timeout        = 1'b0;
`endif

    // Next-state, address advance and completion count
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        sector_cnt_d = sector_cnt_q;
        wrap_d       = 1'b0;
        case (state_q)
            S_INIT: if (init_end) state_d = S_IDLE;
            S_IDLE: begin
                if (!init_end)
                    state_d = S_INIT;
                else if (log_en && (fifo_data_num >= DATA_NUM))
                    state_d = S_REQ;
            end
            S_REQ:  state_d = S_ACK;
            S_ACK: begin
                if (timeout_hit)  state_d = S_ERR;
                else if (wr_busy) state_d = S_BUSY;
            end
            S_BUSY: begin
                if (timeout_hit)   state_d = S_ERR;
                else if (!wr_busy) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (wr_addr_q == END_SECTOR) begin
                    wr_addr_d = START_SECTOR;
                    wrap_d    = 1'b1;
                end else begin
                    wr_addr_d = wr_addr_q + 32'd1;
                end
                if (sector_cnt_q != 32'hFFFF_FFFF)
                    sector_cnt_d = sector_cnt_q + 32'd1;
                state_d = S_IDLE;
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_INIT;
        endcase
        wr_en_d = (state_d == S_REQ);
    end

    // State and output registers; reset overrides every state including S_ERR
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= S_INIT;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= START_SECTOR;
            sector_cnt_q <= '0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            sector_cnt_q <= sector_cnt_d;
            wrap_q       <= wrap_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign sector_cnt  = sector_cnt_q;
    assign wrap_pulse  = wrap_q;
    assign sched_busy  = (state_q == S_REQ) || (state_q == S_ACK) ||
                         (state_q == S_BUSY) || (state_q == S_NEXT);
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_sd_sector_scheduler.sv
// Directed bench for sd_sector_scheduler. Instance a: START 1000 / END 1002,
// instance b: START == END == 7, both driven by the same stimulus.
module tb_sd_sector_scheduler;

    localparam logic [2:0] ST_INIT = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_BUSY = 3'd4;
    localparam logic [2:0] ST_NEXT = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;
`ifdef SD_SCHED_TIMEOUT_EN
    localparam int BUSY_LEN = 20;
`else
    localparam int BUSY_LEN = 100;
`endif

    // clock / reset block
    logic sys_clk = 1'b0;
    logic sys_rst, init_end, log_en, wr_busy;
    logic [11:0] fifo_data_num;
    always #5 sys_clk = ~sys_clk;

    logic        a_wr_en, a_wrap, a_sched_busy, a_err;
    logic [31:0] a_wr_addr, a_sector_cnt;
    logic [2:0]  a_state;
    logic        b_wr_en, b_wrap, b_sched_busy, b_err;
    logic [31:0] b_wr_addr, b_sector_cnt;
    logic [2:0]  b_state;

    sd_sector_scheduler #(
        .DATA_NUM(12'd256), .START_SECTOR(32'd1000), .END_SECTOR(32'd1002), .TIMEOUT_MAX(24'd50)
    ) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .log_en(log_en),
        .fifo_data_num(fifo_data_num), .wr_busy(wr_busy), .wr_en(a_wr_en),
        .wr_addr(a_wr_addr), .sector_cnt(a_sector_cnt), .wrap_pulse(a_wrap),
        .sched_busy(a_sched_busy), .err_timeout(a_err), .state_dbg_o(a_state)
    );

    sd_sector_scheduler #(
        .DATA_NUM(12'd256), .START_SECTOR(32'd7), .END_SECTOR(32'd7), .TIMEOUT_MAX(24'd50)
    ) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .log_en(log_en),
        .fifo_data_num(fifo_data_num), .wr_busy(wr_busy), .wr_en(b_wr_en),
        .wr_addr(b_wr_addr), .sector_cnt(b_sector_cnt), .wrap_pulse(b_wrap),
        .sched_busy(b_sched_busy), .err_timeout(b_err), .state_dbg_o(b_state)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_en_cnt = 0;
    logic        prev_wr_en = 1'b0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // scoreboard: every wr_en pulse pops the expected sector address
    always @(negedge sys_clk) begin
        if (a_wr_en === 1'b1) begin
            logic [31:0] exp_addr;
            wr_en_cnt++;
            exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check("sb_wr_addr", a_wr_addr, exp_addr);
            check("wr_en_width", {31'd0, prev_wr_en}, 32'd0);
            check("b_wr_addr_const", b_wr_addr, 32'd7);
            check("b_wr_en_match", {31'd0, b_wr_en}, 32'd1);
        end
        prev_wr_en = a_wr_en;
    end

    // driver tasks
    task automatic wait_wr_en(input string tag);
        int n = 0;
        @(negedge sys_clk);
        while (a_wr_en !== 1'b1 && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        check({tag, "_wr_en_seen"}, {31'd0, a_wr_en}, 32'd1);
    endtask

    // called at the negedge of the wr_en cycle; returns at the negedge of the first S_IDLE cycle
    task automatic finish_write(input string tag, input int busy_len, input bit drop_log);
        @(posedge sys_clk); #1 wr_busy = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check({tag, "_in_busy"}, {29'd0, a_state}, {29'd0, ST_BUSY});
        if (drop_log) log_en = 1'b0;
        repeat (busy_len) @(posedge sys_clk);
        #1 wr_busy = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check({tag, "_in_next"}, {29'd0, a_state}, {29'd0, ST_NEXT});
        @(posedge sys_clk);
        @(negedge sys_clk);
        check({tag, "_idle"}, {29'd0, a_state}, {29'd0, ST_IDLE});
        check({tag, "_b_wrap"}, {31'd0, b_wrap}, 32'd1);
        check({tag, "_b_addr"}, b_wr_addr, 32'd7);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int c0;
        int n;
        sys_rst = 1'b1; init_end = 1'b0; log_en = 1'b0; wr_busy = 1'b0; fifo_data_num = 12'd0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_wr_en", {31'd0, a_wr_en}, 32'd0);
        check("rst_wr_addr", a_wr_addr, 32'd1000);
        check("rst_sector_cnt", a_sector_cnt, 32'd0);
        check("rst_wrap", {31'd0, a_wrap}, 32'd0);
        check("rst_sched_busy", {31'd0, a_sched_busy}, 32'd0);
        check("rst_err", {31'd0, a_err}, 32'd0);
        check("rst_state", {29'd0, a_state}, {29'd0, ST_INIT});
        check("rst_b_wr_addr", b_wr_addr, 32'd7);
        sys_rst = 1'b0;

        // first sector after init_end at cycle 10
        repeat (10) @(posedge sys_clk);
        #1 init_end = 1'b1; log_en = 1'b1; fifo_data_num = 12'd256;
        exp_q.push_back(32'd1000);
        wait_wr_en("w1");
        fifo_data_num = 12'd0;
        finish_write("w1", BUSY_LEN, 1'b0);
        check("w1_cnt", a_sector_cnt, 32'd1);
        check("w1_addr", a_wr_addr, 32'd1001);
        check("w1_wrap", {31'd0, a_wrap}, 32'd0);
        check("w1_sched_busy", {31'd0, a_sched_busy}, 32'd0);
        check("w1_b_cnt", b_sector_cnt, 32'd1);

        // one word short of a sector: no request; full sector: request next cycle
        fifo_data_num = 12'd255;
        c0 = wr_en_cnt;
        repeat (1000) @(posedge sys_clk);
        check("short_no_wr_en", wr_en_cnt, c0);
        #1 fifo_data_num = 12'd256;
        exp_q.push_back(32'd1001);
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("latency_wr_en", {31'd0, a_wr_en}, 32'd1);
        fifo_data_num = 12'd0;
        finish_write("w2", 10, 1'b0);
        check("w2_cnt", a_sector_cnt, 32'd2);
        check("w2_addr", a_wr_addr, 32'd1002);
        check("w2_wrap", {31'd0, a_wrap}, 32'd0);

        // END_SECTOR write wraps back to START_SECTOR
        fifo_data_num = 12'd256;
        exp_q.push_back(32'd1002);
        wait_wr_en("w3");
        fifo_data_num = 12'd0;
        finish_write("w3", 10, 1'b0);
        check("w3_cnt", a_sector_cnt, 32'd3);
        check("w3_addr_wrapped", a_wr_addr, 32'd1000);
        check("w3_wrap", {31'd0, a_wrap}, 32'd1);
        @(negedge sys_clk);
        check("w3_wrap_one_cycle", {31'd0, a_wrap}, 32'd0);

        // log_en dropped mid-write: sector still completes, then no more requests
        fifo_data_num = 12'd256;
        exp_q.push_back(32'd1000);
        wait_wr_en("w4");
        finish_write("w4", 15, 1'b1);
        check("w4_cnt", a_sector_cnt, 32'd4);
        check("w4_addr", a_wr_addr, 32'd1001);
        check("w4_wrap", {31'd0, a_wrap}, 32'd0);
        c0 = wr_en_cnt;
        repeat (50) @(posedge sys_clk);
        @(negedge sys_clk);
        check("w4_no_more_wr_en", wr_en_cnt, c0);
        check("w4_state_idle", {29'd0, a_state}, {29'd0, ST_IDLE});

        // reset in the middle of a busy write
        log_en = 1'b1;
        exp_q.push_back(32'd1001);
        wait_wr_en("w5");
        fifo_data_num = 12'd0;
        @(posedge sys_clk); #1 wr_busy = 1'b1;
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        check("w5_in_busy", {29'd0, a_state}, {29'd0, ST_BUSY});
        sys_rst = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("mid_rst_wr_en", {31'd0, a_wr_en}, 32'd0);
        check("mid_rst_wr_addr", a_wr_addr, 32'd1000);
        check("mid_rst_cnt", a_sector_cnt, 32'd0);
        check("mid_rst_wrap", {31'd0, a_wrap}, 32'd0);
        check("mid_rst_sched_busy", {31'd0, a_sched_busy}, 32'd0);
        check("mid_rst_err", {31'd0, a_err}, 32'd0);
        check("mid_rst_state", {29'd0, a_state}, {29'd0, ST_INIT});
        check("mid_rst_b_cnt", b_sector_cnt, 32'd0);
        sys_rst = 1'b0;
        wr_busy = 1'b0;

`ifdef SD_SCHED_TIMEOUT_EN
        // controller never acknowledges: watchdog fires 50 cycles after entering S_ACK
        fifo_data_num = 12'd256;
        exp_q.push_back(32'd1000);
        wait_wr_en("w6");
        fifo_data_num = 12'd0;
        @(posedge sys_clk);
        n = 0;
        while (n < 200) begin
            @(posedge sys_clk);
            n++;
            @(negedge sys_clk);
            if (a_err === 1'b1) break;
        end
        check("wdog_cycles", n, 50);
        check("wdog_err", {31'd0, a_err}, 32'd1);
        check("wdog_state", {29'd0, a_state}, {29'd0, ST_ERR});
        check("wdog_addr", a_wr_addr, 32'd1000);
        check("wdog_cnt", a_sector_cnt, 32'd0);
        check("wdog_sched_busy", {31'd0, a_sched_busy}, 32'd0);
        fifo_data_num = 12'd256;
        c0 = wr_en_cnt;
        repeat (30) @(posedge sys_clk);
        @(negedge sys_clk);
        check("err_no_wr_en", wr_en_cnt, c0);
        check("err_sticky", {29'd0, a_state}, {29'd0, ST_ERR});
        fifo_data_num = 12'd0;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("err_rst_err", {31'd0, a_err}, 32'd0);
        check("err_rst_state", {29'd0, a_state}, {29'd0, ST_INIT});
        sys_rst = 1'b0;
`else
        n = 0;
        repeat (20) @(posedge sys_clk);
        @(negedge sys_clk);
        check("no_wdog_err", {31'd0, a_err}, 32'd0);
`endif

        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
